// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches 64-bit lines from a registered instruction memory,
// splits them into four 16-bit instructions and hands them to decode over valid/ready.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_address,
  input  logic [63:0] mem_data_line,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [63:0] cur_line, cur_line_next;
  logic        pf_ok, pf_ok_next;

  logic [15:0] line_base;
  logic        accept;
  logic        crossing;

  assign line_base = {pc[15:3], 3'b000};

  // Outside FETCH the memory is kept busy prefetching the following line.
  assign mem_address = (state == FETCH) ? line_base : line_base + 16'd8;

  assign instr_valid = (state == SERVE);
  assign instr_pc    = pc;
  assign accept      = instr_valid && instr_ready;
  assign crossing    = accept && (pc[2:1] == 2'd3);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    instr = cur_line[63:48];
    case (pc[2:1])
      2'd0:    instr = cur_line[63:48];
      2'd1:    instr = cur_line[47:32];
      2'd2:    instr = cur_line[31:16];
      default: instr = cur_line[15:0];
    endcase
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    cur_line_next = cur_line;
    pf_ok_next    = pf_ok;

    if (redirect_valid) begin
      pc_next    = redirect_pc & 16'hFFFE;
      pf_ok_next = 1'b0;
      state_next = FETCH;
    end else begin
      case (state)
        FETCH: state_next = WAIT;

        WAIT: begin
          cur_line_next = mem_data_line;
          pf_ok_next    = 1'b1;
          state_next    = SERVE;
        end

        SERVE: begin
          if (accept) pc_next = pc + 16'd2;
          if (crossing) begin
            pf_ok_next = 1'b0;
            // A valid prefetch lets the next line start without a bubble.
            if (pf_ok) cur_line_next = mem_data_line;
            else       state_next    = WAIT;
          end else begin
            pf_ok_next = 1'b1;
          end
        end

        default: state_next = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC & 16'hFFFE;
      cur_line <= '0;
      pf_ok    <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      cur_line <= cur_line_next;
      pf_ok    <= pf_ok_next;
    end
  end

endmodule
